// File: rtl/gpio_arb4.sv
// Four-requester GPIO access arbiter: IDLE -> ACCESS -> RESP, one GPIO transaction per grant.
// Define GPIO_ARB_FIXED_PRIO_EN for fixed priority (0 highest); default build is round robin.
module gpio_arb4 #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [3:0]      we_req,
  input  logic [7:0]      a_req,
  input  logic [4*DW-1:0] wd_req,
  output logic [3:0]      gnt,
  output logic [3:0]      done,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  output logic [1:0]      A,
  output logic            WE,
  output logic [DW-1:0]   WD,
  input  logic [DW-1:0]   RD
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                          state;
  logic [NUM_LANES-1:0][1:0]       a_l;
  logic [NUM_LANES-1:0][DW-1:0]    wd_l;
  logic [1:0]                      win;

  assign a_l  = a_req;
  assign wd_l = wd_req;
  assign busy = (state != IDLE);

`ifdef GPIO_ARB_FIXED_PRIO_EN
  always_comb begin
    win = 2'd0;
    for (int i = NUM_LANES-1; i >= 0; i--)
      if (req[i]) win = 2'(i);
  end
`else
  logic [1:0] ptr;
  logic [1:0] w;

  // Walk downward so the lowest offset from ptr overrides and wins.
  always_comb begin
    win = ptr;
    for (int i = NUM_LANES-1; i >= 0; i--)
      if (req[ptr + 2'(i)]) win = ptr + 2'(i);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      rdata <= '0;
      A     <= '0;
      WE    <= 1'b0;
      WD    <= '0;
`ifndef GPIO_ARB_FIXED_PRIO_EN
      ptr   <= '0;
      w     <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (|req) begin
          state <= ACCESS;
          gnt   <= 4'b0001 << win;
          A     <= a_l[win];
          WE    <= we_req[win];
          WD    <= wd_l[win];
`ifndef GPIO_ARB_FIXED_PRIO_EN
          w     <= win;
`endif
        end
        ACCESS: begin
          state <= RESP;
          rdata <= RD;
          done  <= gnt;
          A     <= '0;
          WE    <= 1'b0;
          WD    <= '0;
`ifndef GPIO_ARB_FIXED_PRIO_EN
          ptr   <= w + 2'd1;
`endif
        end
        RESP: begin
          state <= IDLE;
          done  <= '0;
          gnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpio_arb4.sv
// Directed bench for gpio_arb4: a transaction table plus hand sequences for
// round robin, fairness, mid-transaction reset and early request drop.
module tb_gpio_arb4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req, we_req;
  logic [7:0]      a_req;
  logic [4*DW-1:0] wd_req;
  logic [3:0]      gnt, done;
  logic [DW-1:0]   rdata, WD, RD;
  logic            busy, WE;
  logic [1:0]      A;

  int n_chk  = 0;
  int n_fail = 0;

  gpio_arb4 #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .we_req(we_req), .a_req(a_req), .wd_req(wd_req),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .A(A), .WE(WE), .WD(WD), .RD(RD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdf(input logic [1:0] a);
    case (a)
      2'd0: rdf = 32'h1234_5678;
      2'd1: rdf = 32'h1111_1111;
      2'd2: rdf = 32'h2222_2222;
      default: rdf = 32'h3333_3333;
    endcase
  endfunction

  assign RD = rdf(A);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; we_req = '0; a_req = '0; wd_req = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [3:0]  req, we;
    logic [7:0]  a;
    logic [31:0] wdb;
    logic [3:0]  gnt;
    logic [1:0]  ea;
    logic        ewe;
    logic [31:0] ewd, erd;
  } vec_t;

  vec_t tv[5];
  logic [3:0] fair_exp[4];

  initial begin
    tv[0] = '{4'b0001, 4'b0001, 8'h02, 32'hDEAD_BEEF, 4'b0001, 2'd2, 1'b1, 32'hDEAD_BEEF, 32'h2222_2222};
    tv[1] = '{4'b0100, 4'b0000, 8'hC6, 32'h1000_0000, 4'b0100, 2'd0, 1'b0, 32'h1000_0002, 32'h1234_5678};
`ifdef GPIO_ARB_FIXED_PRIO_EN
    tv[2] = '{4'b1010, 4'b1010, 8'hC4, 32'h2000_0000, 4'b0010, 2'd1, 1'b1, 32'h2000_0001, 32'h1111_1111};
    tv[4] = '{4'b1001, 4'b0001, 8'h83, 32'h4000_0000, 4'b0001, 2'd3, 1'b1, 32'h4000_0000, 32'h3333_3333};
    fair_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    tv[2] = '{4'b1010, 4'b1010, 8'hC4, 32'h2000_0000, 4'b1000, 2'd3, 1'b1, 32'h2000_0003, 32'h3333_3333};
    tv[4] = '{4'b1001, 4'b0001, 8'h83, 32'h4000_0000, 4'b1000, 2'd2, 1'b0, 32'h4000_0003, 32'h2222_2222};
    fair_exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
    tv[3] = '{4'b0110, 4'b0000, 8'h24, 32'h3000_0000, 4'b0010, 2'd1, 1'b0, 32'h3000_0001, 32'h1111_1111};

    // Reset state, sampled while rst is held low
    rst = 1'b0; req = '0; we_req = '0; a_req = '0; wd_req = '0;
    #2;
    chk("rst_gnt", gnt, 4'b0);   chk("rst_done", done, 4'b0);
    chk("rst_rdata", rdata, 0);  chk("rst_busy", busy, 1'b0);
    chk("rst_A", A, 2'd0);       chk("rst_WE", WE, 1'b0);
    chk("rst_WD", WD, 0);
    do_reset();

    // Transaction table
    for (int i = 0; i < 5; i++) begin
      req = tv[i].req; we_req = tv[i].we; a_req = tv[i].a;
      wd_req = {tv[i].wdb + 32'd3, tv[i].wdb + 32'd2, tv[i].wdb + 32'd1, tv[i].wdb};
      tick();
      chk($sformatf("v%0d_gnt", i), gnt, tv[i].gnt);
      chk($sformatf("v%0d_A", i), A, tv[i].ea);
      chk($sformatf("v%0d_WE", i), WE, tv[i].ewe);
      chk($sformatf("v%0d_WD", i), WD, tv[i].ewd);
      chk($sformatf("v%0d_busy", i), busy, 1'b1);
      tick();
      chk($sformatf("v%0d_done", i), done, tv[i].gnt);
      chk($sformatf("v%0d_rdata", i), rdata, tv[i].erd);
      chk($sformatf("v%0d_WE_resp", i), WE, 1'b0);
      chk($sformatf("v%0d_A_resp", i), A, 2'd0);
      req = '0;
      tick();
      chk($sformatf("v%0d_idle_busy", i), busy, 1'b0);
      chk($sformatf("v%0d_idle_done", i), done, 4'b0);
      chk($sformatf("v%0d_rdata_hold", i), rdata, tv[i].erd);
    end

    // Round robin with all four requesting, each dropping on its own done
    do_reset();
    req = 4'b1111; we_req = '0; a_req = 8'hE4;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k % 3 == 2) begin
        chk($sformatf("rr_done_k%0d", k), done, 4'b0001 << ((k - 2) / 3));
        chk($sformatf("rr_rdata_k%0d", k), rdata, rdf(2'((k - 2) / 3)));
      end else begin
        chk($sformatf("rr_nodone_k%0d", k), done, 4'b0);
      end
      req = req & ~done;
    end
    req = '0;
    tick();

    // Fairness: two requesters held high permanently
    do_reset();
    req = 4'b0011; a_req = 8'hE4;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("fair_gnt%0d", n), gnt, fair_exp[n]);
      tick();
      tick();
    end
    req = '0;
    tick();

    // Reset during ACCESS of a write, with ptr first moved to 2
    do_reset();
    req = 4'b0010; we_req = '0; a_req = 8'hE4;
    tick(); req = '0; tick(); tick();
    req = 4'b0100; we_req = 4'b0100; a_req = 8'h10;
    tick();
    chk("mid_WE_before", WE, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_WE_async", WE, 1'b0);
    chk("mid_gnt_async", gnt, 4'b0);
    chk("mid_busy_async", busy, 1'b0);
    req = '0; we_req = '0;
    tick();
    chk("mid_no_done", done, 4'b0);
    rst = 1'b1;
    req = 4'b1010; a_req = 8'hE4;
    tick();
    chk("post_rst_gnt", gnt, 4'b0010);
    tick();
    chk("post_rst_done", done, 4'b0010);
    req = '0;
    tick();
    req = 4'b1000;
    tick();
    chk("post_rst_gnt3", gnt, 4'b1000);
    tick();
    chk("post_rst_done3", done, 4'b1000);
    req = '0;
    tick();

    // Early drop of req[2] in ACCESS; req[1] raised during RESP
    req = 4'b0100; we_req = '0; a_req = 8'hE4;
    tick();
    chk("drop_gnt", gnt, 4'b0100);
    req = '0; we_req = 4'b1011; a_req = 8'h00;
    #1;
    chk("drop_A_stable", A, 2'd2);
    chk("drop_WE_stable", WE, 1'b0);
    tick();
    chk("drop_done", done, 4'b0100);
    req = 4'b0010; we_req = '0; a_req = 8'hE4;
    tick();
    chk("drop_done_once", done, 4'b0);
    chk("drop_gnt_clear", gnt, 4'b0);
    tick();
    chk("drop_next_gnt", gnt, 4'b0010);
    req = '0;
    tick();
    chk("drop_next_done", done, 4'b0010);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
